// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_arb_pkg
// Description : Shared types and default constants for the RAM data-port
//               arbiter (owner encoding, request bundle, counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Which requester currently drives the RAM data port
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_t;

    localparam int c_DEF_DATA_WIDTH = 16;
    localparam int c_DEF_ADDR_WIDTH = 12;
    localparam int c_DEF_MAX_WAIT   = 8;
    localparam int c_DEF_LOCK_MAX   = 64;

    // One RAM access as seen from either requester (default system widths)
    typedef struct packed {
        logic                        we;
        logic [c_DEF_ADDR_WIDTH-1:0] addr;
        logic [c_DEF_DATA_WIDTH-1:0] wdata;
    } ram_req_t;

    // Width of a counter that must be able to hold values up to limit-1
    // plus one spare bit so the saturation compare never needs wrap logic
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : ram_port_arbiter_if
// Description : Bundles the cpu, debug and RAM-side signals of the RAM
//               data-port arbiter. master = requesters/RAM side,
//               slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    // cpu side
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    // debug / loader side
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    // ram side
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    // performance counters
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_dbg_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output ram_rdata,
        input  cpu_stall, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_addr, ram_we, ram_wdata,
        input  perf_stall_cnt, perf_dbg_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  ram_rdata,
        output cpu_stall, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_addr, ram_we, ram_wdata,
        output perf_stall_cnt, perf_dbg_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ram_arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_wait_counter
// Description : Saturating up-counter with synchronous clear and an
//               at-limit flag. Used for the debug wait count and the debug
//               lock (burst) count of the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_wait_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    // Count up on inc, hold at LIMIT, clear has priority over inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_at_limit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares the single cpu-side RAM data port between the cpu and
//               a debug/loader requester. The cpu has priority; a debug
//               request denied MAX_WAIT times in a row is forced through.
//               dbg_lock keeps the port for up to LOCK_MAX debug grants.
//               Optional: define RAM_ARB_PERF_EN to build the cpu-stall and
//               debug-grant performance counters (otherwise tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int MAX_WAIT   = c_DEF_MAX_WAIT,
    parameter int LOCK_MAX   = c_DEF_LOCK_MAX
) (
    input  logic                CLK_50,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);

    localparam int c_WAIT_W = cnt_width(MAX_WAIT);
    localparam int c_LOCK_W = cnt_width(LOCK_MAX);

    localparam logic [0:0] c_ST_CPU = OWN_CPU;
    localparam logic [0:0] c_ST_DBG = OWN_DBG;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } port_req_t;

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic       w_own_dbg;
    logic       w_cpu_stall;
    logic       w_dbg_gnt;
    logic       w_dbg_read;
    port_req_t  w_cpu_port;
    port_req_t  w_dbg_port;
    port_req_t  w_sel_port;
    logic       w_wait_inc;
    logic       w_wait_clr;
    logic       w_wait_at_limit;
    logic       w_lock_inc;
    logic       w_lock_clr;
    logic       w_lock_at_limit;
    logic       r_dbg_rvalid;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;

    assign w_own_dbg   = (r_state == c_ST_DBG);
    assign w_cpu_stall = bus.cpu_req & w_own_dbg;
    assign w_dbg_gnt   = bus.dbg_req & w_own_dbg;
    assign w_dbg_read  = w_dbg_gnt & ~bus.dbg_we;

    // Port mux is a pure function of the registered owner, so the RAM never
    // sees a mid-cycle switch between requesters
    always_comb begin
        w_cpu_port.we    = bus.cpu_req & bus.cpu_we;
        w_cpu_port.addr  = bus.cpu_addr;
        w_cpu_port.wdata = bus.cpu_wdata;
        w_dbg_port.we    = bus.dbg_req & bus.dbg_we;
        w_dbg_port.addr  = bus.dbg_addr;
        w_dbg_port.wdata = bus.dbg_wdata;
        w_sel_port       = w_own_dbg ? w_dbg_port : w_cpu_port;
    end

    assign bus.ram_we     = w_sel_port.we;
    assign bus.ram_addr   = w_sel_port.addr;
    assign bus.ram_wdata  = w_sel_port.wdata;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;

    // Ownership decision: cpu wins ties until the debug side has waited
    // MAX_WAIT cycles; a debug grant returns to the cpu unless locked
    always_comb begin
        w_next_state = r_state;
        w_wait_inc   = 1'b0;
        w_wait_clr   = 1'b0;
        w_lock_inc   = 1'b0;
        w_lock_clr   = 1'b0;
        case (r_state)
            c_ST_CPU: begin
                if (!bus.dbg_req) begin
                    w_wait_clr = 1'b1;
                end else if (!bus.cpu_req || w_wait_at_limit) begin
                    w_next_state = c_ST_DBG;
                    w_wait_clr   = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            c_ST_DBG: begin
                if (bus.dbg_req && bus.dbg_lock && !w_lock_at_limit) begin
                    w_lock_inc = 1'b1;
                end else begin
                    w_next_state = c_ST_CPU;
                    w_lock_clr   = 1'b1;
                end
            end
            default: begin
                w_next_state = c_ST_CPU;
                w_wait_clr   = 1'b1;
                w_lock_clr   = 1'b1;
            end
        endcase
    end

    // Owner register; reset hands the port straight back to the cpu
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_CPU;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Consecutive cycles a debug request lost to the cpu
    ram_arb_wait_counter #(
        .WIDTH (c_WAIT_W),
        .LIMIT (MAX_WAIT - 1)
    ) u_wait_cnt (
        .clk        (CLK_50),
        .rst        (reset),
        .i_clear    (w_wait_clr),
        .i_inc      (w_wait_inc),
        .o_at_limit (w_wait_at_limit)
    );

    // Debug grants kept back-to-back under dbg_lock
    ram_arb_wait_counter #(
        .WIDTH (c_LOCK_W),
        .LIMIT (LOCK_MAX - 1)
    ) u_lock_cnt (
        .clk        (CLK_50),
        .rst        (reset),
        .i_clear    (w_lock_clr),
        .i_inc      (w_lock_inc),
        .o_at_limit (w_lock_at_limit)
    );

    // Capture debug read data the cycle after a granted read
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_dbg_read;
            if (w_dbg_read) begin
                r_dbg_rdata <= bus.ram_rdata;
            end
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_dbg_cnt;

    // Free-running wrap-around event counters
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_dbg_cnt   <= '0;
        end else begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'(w_cpu_stall);
            r_perf_dbg_cnt   <= r_perf_dbg_cnt + 32'(w_dbg_gnt);
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall_cnt;
    assign bus.perf_dbg_cnt   = r_perf_dbg_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_dbg_cnt   = '0;
`endif

endmodule
`default_nettype wire
